// File: rtl/morse_key_timer.sv
// morse_key_timer: debounced single-key Morse front end producing dot/dash/decode/clear strobes
module morse_key_timer #(
    parameter int TICK_DIV    = 100000,
    parameter int DEB_MS      = 20,
    parameter int DASH_MS     = 300,
    parameter int GAP_MS      = 700,
    parameter int HOLD_CLR_MS = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_raw,
    output logic       short_n,
    output logic       long_n,
    output logic       decode,
    output logic       clear_all,
    output logic [2:0] sym_cnt,
    output logic       key_led
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DEB_MS + 1);
    localparam int W  = $clog2(HOLD_CLR_MS + 1);

    typedef enum logic [1:0] {IDLE, PRESS, GAP, HELD} state_t;

    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    sync_q;
    logic [DW-1:0] deb_q, deb_d;
    logic          db_q, db_d, db_prev_q;
    logic          tick, key_s, deb_hit, rise, fall;
    state_t        state_q, state_d;
    logic [W-1:0]  dur_q, dur_d, gap_q, gap_d;
    logic [2:0]    sym_q, sym_d;
    logic          dot_q, dot_d, dash_q, dash_d, dec_q, dec_d, clr_q, clr_d;

    function automatic logic [W-1:0] sat(input logic [W-1:0] v);
        return v == W'(HOLD_CLR_MS) ? v : v + 1'b1;
    endfunction

    assign tick    = pre_q == PW'(TICK_DIV - 1);
    assign pre_d   = tick ? '0 : pre_q + 1'b1;
    assign key_s   = sync_q[1];
    assign deb_hit = key_s != db_q && tick && deb_q == DW'(DEB_MS - 1);
    assign deb_d   = (key_s == db_q || deb_hit) ? '0 : deb_q + DW'(tick);
    assign db_d    = db_q ^ deb_hit;
    assign rise    = db_q & ~db_prev_q;
    assign fall    = ~db_q & db_prev_q;

    always_comb begin
        state_d = state_q;
        dur_d   = dur_q;
        gap_d   = gap_q;
        sym_d   = sym_q;
        dot_d   = 1'b0;
        dash_d  = 1'b0;
        dec_d   = 1'b0;
        clr_d   = 1'b0;
        // A full letter is flushed the cycle after its fifth symbol strobe
        if (sym_q == 3'd5) begin
            dec_d = 1'b1;
            sym_d = '0;
        end
        case (state_q)
            IDLE: if (rise) begin
                state_d = PRESS;
                dur_d   = '0;
            end
            PRESS: if (tick && dur_q == W'(HOLD_CLR_MS - 1)) begin
                clr_d   = 1'b1;
                sym_d   = '0;
                state_d = HELD;
            end else if (fall) begin
                dot_d   = dur_q < W'(DASH_MS);
                dash_d  = dur_q >= W'(DASH_MS);
                sym_d   = sym_q + 3'd1;
                state_d = sym_q == 3'd4 ? IDLE : GAP;
                gap_d   = '0;
            end else if (tick) begin
                dur_d = sat(dur_q);
            end
            GAP: if (rise) begin
                state_d = PRESS;
                dur_d   = '0;
            end else if (tick && gap_q == W'(GAP_MS - 1)) begin
                dec_d   = sym_q != 3'd0;
                sym_d   = '0;
                state_d = IDLE;
            end else if (tick) begin
                gap_d = sat(gap_q);
            end
            default: if (fall) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q     <= '0;
            sync_q    <= '0;
            deb_q     <= '0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            state_q   <= IDLE;
            dur_q     <= '0;
            gap_q     <= '0;
            sym_q     <= '0;
            dot_q     <= 1'b0;
            dash_q    <= 1'b0;
            dec_q     <= 1'b0;
            clr_q     <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            sync_q    <= {sync_q[0], key_raw};
            deb_q     <= deb_d;
            db_q      <= db_d;
            db_prev_q <= db_q;
            state_q   <= state_d;
            dur_q     <= dur_d;
            gap_q     <= gap_d;
            sym_q     <= sym_d;
            dot_q     <= dot_d;
            dash_q    <= dash_d;
            dec_q     <= dec_d;
            clr_q     <= clr_d;
        end
    end

    assign short_n   = ~dot_q;
    assign long_n    = ~dash_q;
    assign decode    = dec_q;
    assign clear_all = clr_q;
    assign sym_cnt   = sym_q;
    assign key_led   = db_q;
endmodule

// File: tb/tb_morse_key_timer.sv
// tb_morse_key_timer: randomized press/gap sequences checked against an event-level Morse model
module tb_morse_key_timer;
    localparam int TD = 4;

    logic       clk = 1'b0, rst = 1'b1, key_raw = 1'b0;
    logic       short_n, long_n, decode, clear_all, key_led;
    logic [2:0] sym_cnt;

    int  total = 0, bad = 0, cyc = 0;
    bit  led_seen = 1'b0;
    byte prev_k = 0;

    typedef struct {byte k; int n; bit au;} exp_t;
    typedef struct {byte k; int n; int c;} obs_t;
    exp_t exp_q[$];
    obs_t obs_q[$];
    int   pr_q[$], gp_q[$];

    morse_key_timer #(
        .TICK_DIV(TD), .DEB_MS(2), .DASH_MS(5), .GAP_MS(8), .HOLD_CLR_MS(20)
    ) dut (
        .clk(clk), .rst(rst), .key_raw(key_raw), .short_n(short_n), .long_n(long_n),
        .decode(decode), .clear_all(clear_all), .sym_cnt(sym_cnt), .key_led(key_led)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_short"}, short_n, 1);
        chk({tag, "_long"}, long_n, 1);
        chk({tag, "_dec"}, decode, 0);
        chk({tag, "_clr"}, clear_all, 0);
        chk({tag, "_sym"}, sym_cnt, 0);
        chk({tag, "_led"}, key_led, 0);
    endtask

    always @(negedge clk) begin
        byte k;
        int  act;
        act = int'(!short_n) + int'(!long_n) + int'(decode) + int'(clear_all);
        k = !short_n ? "S" : !long_n ? "L" : decode ? "D" : clear_all ? "C" : 0;
        if (key_led) led_seen = 1'b1;
        if (act != 0) begin
            chk("onehot", act, 1);
            chk("width", k == prev_k, 0);
            obs_q.push_back('{k, int'(sym_cnt), cyc});
        end
        prev_k = k;
    end

    function automatic void push_exp(input byte k, input int n, input bit au);
        exp_q.push_back('{k, n, au});
    endfunction

    // Durations are whole ms chosen clear of every threshold: dot <=4, dash 6..18, clear >=22, letter gap >=10
    task automatic model();
        int n = 0;
        exp_q.delete();
        foreach (pr_q[i]) begin
            if (pr_q[i] >= 22) begin
                push_exp("C", 0, 1'b0);
                n = 0;
            end else begin
                n++;
                push_exp(pr_q[i] <= 4 ? "S" : "L", n, 1'b0);
                if (n == 5) begin
                    push_exp("D", 0, 1'b1);
                    n = 0;
                end else if (gp_q[i] >= 10) begin
                    push_exp("D", 0, 1'b0);
                    n = 0;
                end
            end
        end
    endtask

    task automatic play();
        foreach (pr_q[i]) begin
            key_raw = 1'b1;
            cycles(TD * pr_q[i]);
            key_raw = 1'b0;
            cycles(TD * gp_q[i]);
        end
    endtask

    task automatic verify();
        model();
        cycles(40);
        chk("n_ev", obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk("kind", obs_q[i].k, exp_q[i].k);
            chk("sym", obs_q[i].n, exp_q[i].n);
            if (exp_q[i].k == "D" && i > 0) begin
                int d;
                d = obs_q[i].c - obs_q[i-1].c;
                if (exp_q[i].au) chk("auto_t", d, 1);
                else chk("gap_t", d >= 28 && d <= 33, 1);
            end
        end
        obs_q.delete();
        pr_q.delete();
        gp_q.delete();
    endtask

    initial begin
        #2 rst = 1'b0;
        #1 chk_reset_vals("rst0");
        cycles(3);
        rst = 1'b1;
        cycles(4 + $urandom_range(0, 3));

        pr_q = '{3}; gp_q = '{12};
        key_raw = 1'b1;
        cycles(11);
        chk("led_on", key_led, 1);
        cycles(1);
        key_raw = 1'b0;
        cycles(11);
        chk("led_off", key_led, 0);
        cycles(37);
        verify();

        pr_q = '{7, 2}; gp_q = '{3, 12};
        play(); verify();

        pr_q = '{2, 2, 2, 2, 2}; gp_q = '{3, 3, 3, 3, 12};
        play(); verify();

        pr_q = '{2, 25}; gp_q = '{4, 12};
        play(); verify();

        led_seen = 1'b0;
        repeat (10) begin
            key_raw = 1'b1;
            cycles($urandom_range(1, 4));
            key_raw = 1'b0;
            cycles($urandom_range(6, 12));
        end
        cycles(20);
        chk("glitch_led", led_seen, 0);
        verify();

        pr_q = '{2}; gp_q = '{3};
        play();
        key_raw = 1'b1;
        cycles(8);
        chk("pre_rst_sym", sym_cnt, 1);
        rst = 1'b0;
        #1 chk_reset_vals("rst_mid");
        cycles(8);
        key_raw = 1'b0;
        cycles(4);
        rst = 1'b1;
        cycles(100);
        chk_reset_vals("rst_post");
        verify();

        repeat (4) begin
            int n;
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) begin
                int r;
                r = $urandom_range(0, 9);
                pr_q.push_back(r < 5 ? $urandom_range(2, 4) : r < 9 ? $urandom_range(6, 18) : $urandom_range(22, 26));
                gp_q.push_back(i == n - 1 ? 12 : $urandom_range(0, 1) ? $urandom_range(2, 6) : $urandom_range(10, 14));
            end
            play();
            verify();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/morse_key_timer.md
# morse_key_timer

Single-key Morse front end that sits directly upstream of the Morse decoder/display stage. It synchronises and debounces one raw push-button and times each press and each gap between presses. It emits the one-cycle strobes the decoder consumes: short (dot) and long (dash) symbol strobes, the letter-end decode strobe, and the clear-all strobe. This replaces the separate short/long/decode/clear buttons with one key.

## Interface
- TICK_DIV, 100000: clk cycles per 1 ms tick (100 MHz board clock).
- DEB_MS, 20: ticks the synchronised input must differ from the debounced level before the debounced level flips.
- DASH_MS, 300: press duration threshold; duration < DASH_MS → dot, ≥ DASH_MS → dash.
- GAP_MS, 700: release gap that ends a letter.
- HOLD_CLR_MS, 2000: press duration that means clear-all instead of a symbol.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- key_raw  in  1  raw button level, 1 = pressed, asynchronous to clk.
- short_n  out  1  one-cycle active-low dot strobe.
- long_n  out  1  one-cycle active-low dash strobe.
- decode  out  1  one-cycle active-high letter-end strobe.
- clear_all  out  1  one-cycle active-high clear strobe.
- sym_cnt  out  3  symbols accepted in the current letter, 0..5.
- key_led  out  1  debounced key level.

## Operation
- Prescaler: free-running counter 0..TICK_DIV-1. `tick` is internal and asserts for one cycle when the counter equals TICK_DIV-1.
- Synchroniser: two flops on key_raw, producing key_s.
- Debounce: deb_cnt increments on each tick while key_s ≠ key_db, and clears to 0 on any cycle where key_s = key_db. When deb_cnt reaches DEB_MS, key_db toggles and deb_cnt clears.
- Edge detect on key_db produces rise and fall, each one cycle.
- FSM states: IDLE, PRESS, GAP, HELD.
  - IDLE: on rise → PRESS, dur←0.
  - PRESS: each tick, dur++.
    - If dur reaches HOLD_CLR_MS: clear_all pulses, sym_cnt←0, → HELD.
    - On fall: emit short_n if dur<DASH_MS, else long_n. sym_cnt++.
      - If the new sym_cnt = 5: → IDLE and decode pulses on the following cycle; sym_cnt←0 on the decode cycle.
      - Otherwise → GAP, gap←0.
  - GAP: each tick, gap++. If gap reaches GAP_MS: decode pulses, sym_cnt←0, → IDLE. On rise → PRESS, dur←0; no decode is issued.
  - HELD: ignore ticks. On fall → IDLE, no symbol strobe.
- The dur and gap counters saturate and never wrap. Their width is ceil(log2(HOLD_CLR_MS+1)).
- A decode is never issued when sym_cnt = 0.

## Timing
- Reset values: short_n=1, long_n=1, decode=0, clear_all=0, sym_cnt=0, key_led=0. FSM resets to IDLE; all counters reset to 0.
- key_raw to key_db latency: 2 sync cycles plus DEB_MS ticks (±1 tick of prescaler phase).
- Symbol strobe: asserted the cycle after fall is detected, for exactly 1 cycle.
- At most one of short_n, long_n, decode, clear_all is active in any cycle.
- Five-symbol auto-decode: decode is asserted exactly 1 cycle after the fifth symbol strobe.
- GAP expiry: decode is asserted in the cycle after the tick that brings gap to GAP_MS.
- Simultaneous events:
  - fall with tick: fall wins, dur is not incremented before classification.
  - rise with tick in GAP: rise wins, no decode.
  - HOLD_CLR_MS reached with fall in the same cycle: clear wins, no symbol.
- Reset mid-press or mid-gap: all strobes return high/low immediately (asynchronously). No strobe is emitted on reset release.
- Glitches shorter than DEB_MS ticks never change key_led and never produce strobes.

## Test plan
Bench parameters: TICK_DIV=4, DEB_MS=2, DASH_MS=5, GAP_MS=8, HOLD_CLR_MS=20.
- Press held 3 ms, released, then idle 10 ms → one short_n pulse, then decode 1 cycle wide about 8 ms later; sym_cnt goes 0→1→0.
- Press held 7 ms, release, then press 2 ms within 4 ms of release, then idle → long_n then short_n, no decode in between, one decode at the end; sym_cnt peaks at 2.
- Five 2 ms presses separated by 3 ms gaps → five short_n pulses; decode 1 cycle after the fifth; sym_cnt=0 afterwards; no second decode when the gap expires.
- Hold 25 ms after one earlier dot → clear_all pulses once at about 20 ms, no symbol strobe on release, sym_cnt=0, no decode.
- 1 ms glitch pulses on key_raw → key_led stays 0, all strobes stay idle.
- Assert rst in the middle of a 4 ms press, then release rst → all outputs at reset values, and no short_n when the key is later released.
